// File: rtl/branch_resolve_ctrl_if.sv
// Bundle between ID-stage decode, the branch comparator, IF redirect and debug statistics.
interface branch_resolve_ctrl_if #(parameter int CNT_W = 16);
   logic              br_valid;
   logic [2:0]        br_op;
   logic [4:0]        rs_idx, rt_idx;
   logic [31:0]       rs_data, rt_data;
   logic [31:0]       pc4;
   logic [15:0]       offset;
   logic              ex_reg_write;
   logic [4:0]        ex_rd;
   logic              mem_reg_write, mem_is_load;
   logic [4:0]        mem_rd;
   logic [31:0]       mem_data;
   logic              cmp_result;
   logic [31:0]       cmp_in_a, cmp_in_b;
   logic [2:0]        cmp_control;
   logic              stall, redirect, flush;
   logic [31:0]       target;
   logic [CNT_W-1:0]  branch_count, taken_count, stall_count;
   logic              hazard_err;

   modport slave (
      input  br_valid, br_op, rs_idx, rt_idx, rs_data, rt_data, pc4, offset,
             ex_reg_write, ex_rd, mem_reg_write, mem_is_load, mem_rd, mem_data, cmp_result,
      output cmp_in_a, cmp_in_b, cmp_control, stall, redirect, flush, target,
             branch_count, taken_count, stall_count, hazard_err
   );

   modport master (
      output br_valid, br_op, rs_idx, rt_idx, rs_data, rt_data, pc4, offset,
             ex_reg_write, ex_rd, mem_reg_write, mem_is_load, mem_rd, mem_data, cmp_result,
      input  cmp_in_a, cmp_in_b, cmp_control, stall, redirect, flush, target,
             branch_count, taken_count, stall_count, hazard_err
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch controller: hazard stall, MEM forwarding, comparator drive,
// zero-latency redirect and saturating debug statistics.
module branch_resolve_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_resolve_ctrl_if.slave  bus
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0]    WMAX = WW'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CMAX = '1;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state, state_nx;
   logic [WW-1:0]    wait_cnt, wait_nx;
   logic [CNT_W-1:0] branch_cnt, taken_cnt, stall_cnt;
   logic             err;

   logic        rt_used, reserved, haz_rs, haz_rt, hazard, resolve, stall;
   logic [31:0] fwd_rs, fwd_rt;

   // r0 never stalls; loads in MEM are not yet forwardable
   function automatic logic src_hazard(input logic [4:0] r);
      return (r != 5'd0) &&
             ((bus.ex_reg_write && bus.ex_rd == r) ||
              (bus.mem_reg_write && bus.mem_is_load && bus.mem_rd == r));
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
      return (bus.mem_reg_write && !bus.mem_is_load && bus.mem_rd == r) ? bus.mem_data : rf;
   endfunction

   assign rt_used  = (bus.br_op == 3'b000) || (bus.br_op == 3'b101);
   assign reserved = (bus.br_op[2:1] == 2'b11);
   assign haz_rs   = src_hazard(bus.rs_idx);
   assign haz_rt   = rt_used && src_hazard(bus.rt_idx);
   assign hazard   = !reserved && (haz_rs || haz_rt);
   assign stall    = rst_n && bus.br_valid && hazard;
   assign resolve  = bus.br_valid && !hazard && !reserved;

   assign fwd_rs = fwd(bus.rs_idx, bus.rs_data);
   assign fwd_rt = fwd(bus.rt_idx, bus.rt_data);

   always_comb begin
      bus.cmp_in_b = 32'd0;
      case (bus.br_op)
         3'b000, 3'b101: bus.cmp_in_b = fwd_rt;
         3'b001, 3'b100: bus.cmp_in_b = {27'd0, bus.rt_idx};
         default:        bus.cmp_in_b = 32'd0;
      endcase
   end

   assign bus.cmp_in_a    = fwd_rs;
   assign bus.cmp_control = bus.br_op;
   assign bus.stall       = stall;
   assign bus.redirect    = rst_n && resolve && bus.cmp_result;
   assign bus.flush       = bus.redirect;
   assign bus.target      = bus.pc4 + {{14{bus.offset[15]}}, bus.offset, 2'b00};

   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      case (state)
         IDLE: if (stall) begin
            state_nx = WAIT;
            wait_nx  = WW'(1);
         end
         WAIT: if (stall) begin
            wait_nx = (wait_cnt < WMAX) ? wait_cnt + WW'(1) : wait_cnt;
         end else begin
            // resolved or squashed upstream
            state_nx = IDLE;
            wait_nx  = '0;
         end
         default: begin
            state_nx = IDLE;
            wait_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         branch_cnt <= '0;
         taken_cnt  <= '0;
         stall_cnt  <= '0;
         err        <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         if (stall) begin
            if (stall_cnt != CMAX) stall_cnt <= stall_cnt + 1'b1;
            if (wait_nx == WMAX)   err       <= 1'b1;
         end
         if (resolve) begin
            if (branch_cnt != CMAX)                    branch_cnt <= branch_cnt + 1'b1;
            if (bus.cmp_result && taken_cnt != CMAX)   taken_cnt  <= taken_cnt + 1'b1;
         end
      end
   end

   assign bus.branch_count = branch_cnt;
   assign bus.taken_count  = taken_cnt;
   assign bus.stall_count  = stall_cnt;
   assign bus.hazard_err   = err;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed plus randomized bench for branch_resolve_ctrl against a cycle-level reference model.
module tb_branch_resolve_ctrl;
   localparam int CNT_W    = 4;
   localparam int MAX_WAIT = 3;
   localparam int CMAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   branch_resolve_ctrl_if #(.CNT_W(CNT_W)) bus();
   branch_resolve_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fails  = 0;
   int m_br, m_tk, m_st, m_run;
   bit m_err, m_last_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_haz(input logic [4:0] r);
      if (r == 0) return 0;
      if (bus.ex_reg_write && bus.ex_rd == r) return 1;
      if (bus.mem_reg_write && bus.mem_is_load && bus.mem_rd == r) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] ref_val(input logic [4:0] r, input logic [31:0] rf);
      if (bus.mem_reg_write && !bus.mem_is_load && bus.mem_rd == r) return bus.mem_data;
      return rf;
   endfunction

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_reset();
      m_br = 0; m_tk = 0; m_st = 0; m_run = 0; m_err = 0; m_last_stall = 0;
   endtask

   // Entered at a negedge with inputs already applied; leaves at the next negedge.
   task automatic step();
      int op, off;
      bit two_src, rsv, hz, exp_stall, res, exp_red;
      logic [31:0] exp_b, exp_t;
      #1;
      op      = int'(bus.br_op);
      two_src = (op == 0 || op == 5);
      rsv     = (op >= 6);
      hz      = !rsv && (ref_haz(bus.rs_idx) || (two_src && ref_haz(bus.rt_idx)));
      exp_stall = bus.br_valid && hz;
      res     = bus.br_valid && !hz && !rsv;
      exp_red = res && bus.cmp_result;
      off     = int'($signed(bus.offset));
      exp_t   = bus.pc4 + 32'(off * 4);
      if (two_src)                exp_b = ref_val(bus.rt_idx, bus.rt_data);
      else if (op == 1 || op == 4) exp_b = 32'(bus.rt_idx);
      else                         exp_b = 32'd0;
      chk("stall",    32'(bus.stall),    32'(exp_stall));
      chk("redirect", 32'(bus.redirect), 32'(exp_red));
      chk("flush",    32'(bus.flush),    32'(exp_red));
      chk("target",   bus.target,        exp_t);
      chk("cmp_in_a", bus.cmp_in_a,      ref_val(bus.rs_idx, bus.rs_data));
      chk("cmp_in_b", bus.cmp_in_b,      exp_b);
      chk("cmp_ctl",  32'(bus.cmp_control), 32'(op));
      @(posedge clk);
      if (exp_stall) begin
         m_st  = sat(m_st);
         m_run = (m_run < MAX_WAIT) ? m_run + 1 : m_run;
         if (m_run >= MAX_WAIT) m_err = 1;
      end else begin
         m_run = 0;
      end
      if (res) begin
         m_br = sat(m_br);
         if (bus.cmp_result) m_tk = sat(m_tk);
      end
      m_last_stall = exp_stall;
      #1;
      chk("branch_count", 32'(bus.branch_count), 32'(m_br));
      chk("taken_count",  32'(bus.taken_count),  32'(m_tk));
      chk("stall_count",  32'(bus.stall_count),  32'(m_st));
      chk("hazard_err",   32'(bus.hazard_err),   32'(m_err));
      @(negedge clk);
   endtask

   task automatic set_br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rsd, input logic [31:0] rtd);
      bus.br_valid = 1'b1; bus.br_op = op; bus.rs_idx = rs; bus.rt_idx = rt;
      bus.rs_data = rsd; bus.rt_data = rtd;
   endtask

   task automatic clear_haz();
      bus.ex_reg_write = 1'b0; bus.ex_rd = '0;
      bus.mem_reg_write = 1'b0; bus.mem_is_load = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
   endtask

   function automatic logic [4:0] pick_rd(input logic [4:0] a, input logic [4:0] b);
      case ($urandom_range(3))
         0: return a;
         1: return b;
         2: return 5'd0;
         default: return 5'($urandom_range(7));
      endcase
   endfunction

   initial begin
      rst_n = 1'b0;
      bus.br_valid = 1'b0; bus.br_op = '0; bus.rs_idx = '0; bus.rt_idx = '0;
      bus.rs_data = '0; bus.rt_data = '0; bus.pc4 = '0; bus.offset = '0; bus.cmp_result = 1'b0;
      clear_haz();
      model_reset();
      #1;
      chk("rst_stall",  32'(bus.stall), 32'd0);
      chk("rst_branch", 32'(bus.branch_count), 32'd0);
      chk("rst_err",    32'(bus.hazard_err), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Taken BEQ, no hazard
      set_br(3'b000, 5'd1, 5'd2, 32'd5, 32'd5);
      bus.pc4 = 32'h100; bus.offset = 16'hFFFE; bus.cmp_result = 1'b1;
      step();
      chk("beq_target", bus.target, 32'hF8);
      chk("beq_branch", 32'(bus.branch_count), 32'd1);
      chk("beq_taken",  32'(bus.taken_count), 32'd1);

      // EX hazard on rs for one cycle
      set_br(3'b101, 5'd3, 5'd4, 32'd9, 32'd8);
      bus.cmp_result = 1'b0; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd3;
      step();
      clear_haz();
      step();
      chk("ex_stall_cnt", 32'(bus.stall_count), 32'd1);

      // MEM ALU forwarding then MEM load stall
      set_br(3'b000, 5'd1, 5'd7, 32'd1, 32'd2);
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h1234;
      step();
      chk("fwd_b", bus.cmp_in_b, 32'h1234);
      bus.mem_is_load = 1'b1;
      step();
      clear_haz();
      step();

      // BGEZ encodes rt in cmp_in_b, rt hazard ignored; r0 never stalls
      set_br(3'b001, 5'd2, 5'd1, 32'd3, 32'd0);
      bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd1;
      step();
      chk("bgez_b", bus.cmp_in_b, 32'd1);
      set_br(3'b000, 5'd0, 5'd0, 32'd0, 32'd0);
      bus.ex_rd = 5'd0;
      step();
      chk("r0_stall", 32'(bus.stall), 32'd0);

      // Timeout
      set_br(3'b000, 5'd4, 5'd5, 32'd1, 32'd1);
      bus.ex_rd = 5'd4;
      repeat (3) step();
      clear_haz();
      step();
      chk("timeout_err", 32'(bus.hazard_err), 32'd1);

      // Reset in second stall cycle
      set_br(3'b101, 5'd6, 5'd2, 32'd1, 32'd2);
      bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd6;
      step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_stall", 32'(bus.stall), 32'd0);
      chk("mid_rst_st",    32'(bus.stall_count), 32'd0);
      chk("mid_rst_br",    32'(bus.branch_count), 32'd0);
      chk("mid_rst_err",   32'(bus.hazard_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_st", 32'(bus.stall_count), 32'd1);
      clear_haz();
      step();

      // Randomized traffic; small counters also exercise saturation
      for (int i = 0; i < 400; i++) begin
         if (!m_last_stall || $urandom_range(15) == 0) begin
            if ($urandom_range(7) == 0) bus.br_valid = 1'b0;
            else begin
               set_br(3'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                      $urandom, $urandom);
               bus.pc4 = $urandom; bus.offset = 16'($urandom);
            end
         end
         bus.cmp_result    = 1'($urandom_range(1));
         bus.ex_reg_write  = ($urandom_range(2) == 0);
         bus.ex_rd         = pick_rd(bus.rs_idx, bus.rt_idx);
         bus.mem_reg_write = ($urandom_range(1) == 0);
         bus.mem_is_load   = ($urandom_range(2) == 0);
         bus.mem_rd        = pick_rd(bus.rs_idx, bus.rt_idx);
         bus.mem_data      = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
